// File: rtl/xif_coproc_tracker_if.sv
// Issue/register/commit/result handshake bundle between the CPU and the coprocessor
// tracker, plus the dispatch and completion ports toward the execution unit.
interface xif_coproc_tracker_if #(
  parameter int unsigned IdWidth   = 3,
  parameter int unsigned DataWidth = 64
);
  logic                   issue_valid_i;
  logic                   issue_ready_o;
  logic [IdWidth-1:0]     issue_id_i;
  logic [4:0]             issue_rd_i;
  logic                   dec_accept_i;
  logic                   dec_writeback_i;
  logic                   issue_accept_o;
  logic                   issue_writeback_o;
  logic                   register_valid_i;
  logic                   register_ready_o;
  logic [IdWidth-1:0]     register_id_i;
  logic [2*DataWidth-1:0] register_rs_i;
  logic                   commit_valid_i;
  logic [IdWidth-1:0]     commit_id_i;
  logic                   commit_kill_i;
  logic                   exec_valid_o;
  logic                   exec_ready_i;
  logic [IdWidth-1:0]     exec_id_o;
  logic [2*DataWidth-1:0] exec_rs_o;
  logic                   done_valid_i;
  logic [IdWidth-1:0]     done_id_i;
  logic [DataWidth-1:0]   done_data_i;
  logic                   done_exc_i;
  logic [5:0]             done_exccode_i;
  logic                   result_valid_o;
  logic                   result_ready_i;
  logic [IdWidth-1:0]     result_id_o;
  logic [DataWidth-1:0]   result_data_o;
  logic [4:0]             result_rd_o;
  logic                   result_we_o;
  logic                   result_exc_o;
  logic [5:0]             result_exccode_o;
  logic                   proto_err_o;

  modport slave (
    input  issue_valid_i, issue_id_i, issue_rd_i, dec_accept_i, dec_writeback_i,
    input  register_valid_i, register_id_i, register_rs_i,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    input  exec_ready_i,
    input  done_valid_i, done_id_i, done_data_i, done_exc_i, done_exccode_i,
    input  result_ready_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o, register_ready_o,
    output exec_valid_o, exec_id_o, exec_rs_o,
    output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
    output result_exc_o, result_exccode_o, proto_err_o
  );

  modport master (
    output issue_valid_i, issue_id_i, issue_rd_i, dec_accept_i, dec_writeback_i,
    output register_valid_i, register_id_i, register_rs_i,
    output commit_valid_i, commit_id_i, commit_kill_i,
    output exec_ready_i,
    output done_valid_i, done_id_i, done_data_i, done_exc_i, done_exccode_i,
    output result_ready_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o, register_ready_o,
    input  exec_valid_o, exec_id_o, exec_rs_o,
    input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
    input  result_exc_o, result_exccode_o, proto_err_o
  );
endinterface

// File: rtl/xif_coproc_tracker.sv
// In-order tracker for offloaded instructions: joins operands with commit/kill,
// dispatches committed work in order and returns results in issue order.
module xif_coproc_tracker #(
  parameter int unsigned NrEntries = 4,
  parameter int unsigned IdWidth   = 3,
  parameter int unsigned DataWidth = 64
) (
  input logic                clk_i,
  input logic                rst_i,
  xif_coproc_tracker_if.slave xif
);
  localparam int unsigned PtrW = $clog2(NrEntries);
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   cnt_t;

  typedef struct packed {
    logic                   valid;
    logic [IdWidth-1:0]     id;
    logic [4:0]             rd;
    logic                   we;
    logic                   ops_v;
    logic [2*DataWidth-1:0] rs;
    logic                   commit_v;
    logic                   kill;
    logic                   disp;
    logic                   done;
    logic [DataWidth-1:0]   data;
    logic                   exc;
    logic [5:0]             exccode;
  } entry_t;

  entry_t table_q [NrEntries];
  entry_t table_d [NrEntries];
  ptr_t   head_q, head_d, disp_q, disp_d, tail_q, tail_d;
  cnt_t   count_q, count_d;
  logic   proto_err_q, proto_err_d;

  entry_t head_e, disp_e, new_e;
  logic   alloc, disp_go, disp_skip, exec_fire, res_valid, retire;
  logic   reg_hit, done_hit, issue_dup;

  assign head_e    = table_q[head_q];
  assign disp_e    = table_q[disp_q];
  assign alloc     = xif.issue_valid_i & xif.issue_ready_o & xif.dec_accept_i;
  assign disp_go   = disp_e.valid & disp_e.ops_v & disp_e.commit_v & ~disp_e.kill & ~disp_e.disp;
  assign disp_skip = disp_e.valid & disp_e.kill & ~disp_e.disp;
  assign exec_fire = disp_go & xif.exec_ready_i;
  assign res_valid = head_e.valid & head_e.done & ~head_e.kill;
  // A killed head frees immediately; a completed head waits for the CPU to take it.
  assign retire    = (head_e.valid & head_e.kill) | (res_valid & xif.result_ready_i);

  assign xif.issue_ready_o     = ~rst_i & (count_q != cnt_t'(NrEntries));
  assign xif.issue_accept_o    = xif.dec_accept_i;
  assign xif.issue_writeback_o = xif.dec_accept_i & xif.dec_writeback_i;
  assign xif.register_ready_o  = 1'b1;
  assign xif.exec_valid_o      = disp_go;
  assign xif.exec_id_o         = disp_go ? disp_e.id : '0;
  assign xif.exec_rs_o         = disp_go ? disp_e.rs : '0;
  assign xif.result_valid_o    = res_valid;
  assign xif.result_id_o       = res_valid ? head_e.id : '0;
  assign xif.result_data_o     = res_valid ? head_e.data : '0;
  assign xif.result_rd_o       = res_valid ? head_e.rd : '0;
  assign xif.result_we_o       = res_valid & head_e.we & ~head_e.exc;
  assign xif.result_exc_o      = res_valid & head_e.exc;
  assign xif.result_exccode_o  = res_valid ? head_e.exccode : '0;
  assign xif.proto_err_o       = proto_err_q;

  always_comb begin
    // NOTE: every next-state variable starts from its current value so no path leaves one unassigned (no latches).
    table_d     = table_q;
    head_d      = head_q;
    disp_d      = disp_q;
    tail_d      = tail_q;
    proto_err_d = proto_err_q;
    reg_hit     = 1'b0;
    done_hit    = 1'b0;
    issue_dup   = 1'b0;
    new_e       = '0;

    for (int i = 0; i < int'(NrEntries); i++) begin
      if (table_q[i].valid && table_q[i].id == xif.issue_id_i) issue_dup = 1'b1;
      if (xif.register_valid_i && table_q[i].valid && !table_q[i].ops_v &&
          table_q[i].id == xif.register_id_i) begin
        table_d[i].ops_v = 1'b1;
        table_d[i].rs    = xif.register_rs_i;
        reg_hit          = 1'b1;
      end
      if (xif.commit_valid_i && table_q[i].valid && table_q[i].id == xif.commit_id_i) begin
        table_d[i].commit_v = 1'b1;
        if (xif.commit_kill_i) table_d[i].kill = 1'b1;
      end
      if (xif.done_valid_i && table_q[i].valid && table_q[i].disp && !table_q[i].done &&
          table_q[i].id == xif.done_id_i) begin
        table_d[i].done    = 1'b1;
        table_d[i].data    = xif.done_data_i;
        table_d[i].exc     = xif.done_exc_i;
        table_d[i].exccode = xif.done_exccode_i;
        done_hit           = 1'b1;
      end
    end
    if ((xif.register_valid_i && !reg_hit) || (xif.done_valid_i && !done_hit)) proto_err_d = 1'b1;

    if (exec_fire) table_d[disp_q].disp = 1'b1;
    if (exec_fire || disp_skip) disp_d = disp_q + ptr_t'(1);

    if (retire) begin
      table_d[head_q].valid = 1'b0;
      head_d                = head_q + ptr_t'(1);
    end

    if (alloc) begin
      new_e.valid     = 1'b1;
      new_e.id        = xif.issue_id_i;
      new_e.rd        = xif.issue_rd_i;
      new_e.we        = xif.dec_writeback_i;
      table_d[tail_q] = new_e;
      tail_d          = tail_q + ptr_t'(1);
    end

    count_d = count_q + cnt_t'(alloc) - cnt_t'(retire);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the table is small, so it is cleared entirely rather than just its valid bits; no stale fields survive a reset.
      for (int i = 0; i < int'(NrEntries); i++) table_q[i] <= '0;
      head_q      <= '0;
      disp_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments only, so every flop samples pre-edge values.
      table_q     <= table_d;
      head_q      <= head_d;
      disp_q      <= disp_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
    end
  end

  a_issue_id_unique: assert property (@(posedge clk_i) disable iff (rst_i) alloc |-> !issue_dup);
  a_done_dispatched: assert property (@(posedge clk_i) disable iff (rst_i) xif.done_valid_i |-> done_hit);
endmodule

// File: tb/tb_xif_coproc_tracker.sv
// Directed bench for xif_coproc_tracker: an issue-vector table plus hand-written
// sequences for dispatch, kill, out-of-order completion, back-pressure and reset.
module tb_xif_coproc_tracker;
  localparam int unsigned IdW = 3;
  localparam int unsigned DW  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  xif_coproc_tracker_if #(.IdWidth(IdW), .DataWidth(DW)) bus ();

  xif_coproc_tracker #(.NrEntries(4), .IdWidth(IdW), .DataWidth(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .xif   (bus.slave)
  );

  typedef struct {
    logic           valid;
    logic [IdW-1:0] id;
    logic [4:0]     rd;
    logic           acc;
    logic           wb;
    logic           exp_accept;
    logic           exp_wb;
    logic           exp_ready;
  } issue_vec_t;

  issue_vec_t vecs [6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.issue_valid_i    = 1'b0;
    bus.issue_id_i       = '0;
    bus.issue_rd_i       = '0;
    bus.dec_accept_i     = 1'b0;
    bus.dec_writeback_i  = 1'b0;
    bus.register_valid_i = 1'b0;
    bus.register_id_i    = '0;
    bus.register_rs_i    = '0;
    bus.commit_valid_i   = 1'b0;
    bus.commit_id_i      = '0;
    bus.commit_kill_i    = 1'b0;
    bus.exec_ready_i     = 1'b0;
    bus.done_valid_i     = 1'b0;
    bus.done_id_i        = '0;
    bus.done_data_i      = '0;
    bus.done_exc_i       = 1'b0;
    bus.done_exccode_i   = '0;
    bus.result_ready_i   = 1'b0;
  endtask

  task automatic issue(input logic [IdW-1:0] id, input logic [4:0] rd, input logic acc, input logic wb);
    bus.issue_valid_i   = 1'b1;
    bus.issue_id_i      = id;
    bus.issue_rd_i      = rd;
    bus.dec_accept_i    = acc;
    bus.dec_writeback_i = wb;
  endtask

  task automatic reg_ops(input logic [IdW-1:0] id, input logic [DW-1:0] rs1, input logic [DW-1:0] rs0);
    bus.register_valid_i = 1'b1;
    bus.register_id_i    = id;
    bus.register_rs_i    = {rs1, rs0};
  endtask

  task automatic commit(input logic [IdW-1:0] id, input logic kill);
    bus.commit_valid_i = 1'b1;
    bus.commit_id_i    = id;
    bus.commit_kill_i  = kill;
  endtask

  task automatic done(input logic [IdW-1:0] id, input logic [DW-1:0] data, input logic exc, input logic [5:0] code);
    bus.done_valid_i   = 1'b1;
    bus.done_id_i      = id;
    bus.done_data_i    = data;
    bus.done_exc_i     = exc;
    bus.done_exccode_i = code;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 3'd0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 3'd1, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 3'd4, 5'd14, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 3'd2, 5'd12, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 3'd3, 5'd13, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 3'd5, 5'd15, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    idle_inputs();
    next(); next();
    mid();
    check("rst_issue_ready",    bus.issue_ready_o,    0);
    check("rst_register_ready", bus.register_ready_o, 1);
    check("rst_exec_valid",     bus.exec_valid_o,     0);
    check("rst_result_valid",   bus.result_valid_o,   0);
    check("rst_result_data",    bus.result_data_o,    0);
    check("rst_proto_err",      bus.proto_err_o,      0);
    next(); rst = 1'b0;
    mid();
    check("post_rst_issue_ready", bus.issue_ready_o, 1);

    // Single instruction end to end
    next(); issue(3'd3, 5'd5, 1'b1, 1'b1);
    mid();
    check("a_accept", bus.issue_accept_o, 1);
    check("a_writeback", bus.issue_writeback_o, 1);
    next(); idle_inputs(); reg_ops(3'd3, 64'd7, 64'd9); commit(3'd3, 1'b0);
    mid();
    check("a_exec_not_early", bus.exec_valid_o, 0);
    next(); idle_inputs(); bus.exec_ready_i = 1'b1;
    mid();
    check("a_exec_valid", bus.exec_valid_o, 1);
    check("a_exec_id",    bus.exec_id_o, 3);
    check("a_exec_rs",    bus.exec_rs_o, {64'd7, 64'd9});
    next(); idle_inputs(); done(3'd3, 64'h42, 1'b0, 6'd0);
    mid();
    check("a_exec_dropped", bus.exec_valid_o, 0);
    check("a_result_not_early", bus.result_valid_o, 0);
    next(); idle_inputs(); bus.result_ready_i = 1'b1;
    mid();
    check("a_result_valid", bus.result_valid_o, 1);
    check("a_result_id",    bus.result_id_o, 3);
    check("a_result_rd",    bus.result_rd_o, 5);
    check("a_result_we",    bus.result_we_o, 1);
    check("a_result_data",  bus.result_data_o, 64'h42);
    check("a_result_exc",   bus.result_exc_o, 0);
    next(); idle_inputs();
    mid();
    check("a_result_gone", bus.result_valid_o, 0);

    // Issue table: fill to 4 entries, with one rejected id in between
    for (int i = 0; i < 6; i++) begin
      next(); idle_inputs();
      issue(vecs[i].id, vecs[i].rd, vecs[i].acc, vecs[i].wb);
      bus.issue_valid_i = vecs[i].valid;
      mid();
      check($sformatf("vec%0d_accept", i),    bus.issue_accept_o,    vecs[i].exp_accept);
      check($sformatf("vec%0d_writeback", i), bus.issue_writeback_o, vecs[i].exp_wb);
      check($sformatf("vec%0d_ready", i),     bus.issue_ready_o,     vecs[i].exp_ready);
      check($sformatf("vec%0d_no_exec", i),   bus.exec_valid_o,      0);
    end

    // Retire id 0 from a full table
    next(); idle_inputs(); reg_ops(3'd0, 64'd1, 64'd2); commit(3'd0, 1'b0);
    mid();
    check("full_ready_low", bus.issue_ready_o, 0);
    next(); idle_inputs(); bus.exec_ready_i = 1'b1;
    mid();
    check("full_exec_valid", bus.exec_valid_o, 1);
    check("full_exec_id",    bus.exec_id_o, 0);
    next(); idle_inputs(); done(3'd0, 64'h11, 1'b0, 6'd0);
    mid();
    next(); idle_inputs(); bus.result_ready_i = 1'b1;
    mid();
    check("full_result_valid", bus.result_valid_o, 1);
    check("full_result_id",    bus.result_id_o, 0);
    check("full_result_rd",    bus.result_rd_o, 10);
    check("full_result_data",  bus.result_data_o, 64'h11);
    check("full_ready_still_low", bus.issue_ready_o, 0);
    next(); idle_inputs();
    mid();
    check("full_ready_after_retire", bus.issue_ready_o, 1);
    check("full_result_gone", bus.result_valid_o, 0);

    // Kill the remaining ids 1..3; nothing may be dispatched or returned
    for (int k = 1; k <= 3; k++) begin
      next(); idle_inputs(); commit(IdW'(k), 1'b1); bus.exec_ready_i = 1'b1;
      mid();
      check($sformatf("kill%0d_no_exec", k),   bus.exec_valid_o, 0);
      check($sformatf("kill%0d_no_result", k), bus.result_valid_o, 0);
    end
    for (int k = 0; k < 4; k++) begin
      next(); idle_inputs(); bus.exec_ready_i = 1'b1; bus.result_ready_i = 1'b1;
      mid();
      check("drain_no_exec",   bus.exec_valid_o, 0);
      check("drain_no_result", bus.result_valid_o, 0);
    end

    // Kill id 1, commit id 2
    next(); idle_inputs(); issue(3'd1, 5'd21, 1'b1, 1'b1);
    next(); idle_inputs(); issue(3'd2, 5'd22, 1'b1, 1'b1);
    next(); idle_inputs(); reg_ops(3'd1, 64'd3, 64'd4); commit(3'd1, 1'b1);
    next(); idle_inputs(); reg_ops(3'd2, 64'ha, 64'hb); commit(3'd2, 1'b0);
    mid();
    check("c_killed_not_dispatched", bus.exec_valid_o, 0);
    check("c_killed_no_result", bus.result_valid_o, 0);
    next(); idle_inputs(); bus.exec_ready_i = 1'b1;
    mid();
    check("c_exec_valid", bus.exec_valid_o, 1);
    check("c_exec_id",    bus.exec_id_o, 2);
    check("c_exec_rs",    bus.exec_rs_o, {64'ha, 64'hb});
    check("c_no_result",  bus.result_valid_o, 0);
    next(); idle_inputs(); done(3'd2, 64'h22, 1'b0, 6'd0);
    mid();
    next(); idle_inputs(); bus.result_ready_i = 1'b1;
    mid();
    check("c_result_valid", bus.result_valid_o, 1);
    check("c_result_id",    bus.result_id_o, 2);
    check("c_result_rd",    bus.result_rd_o, 22);
    check("c_result_data",  bus.result_data_o, 64'h22);
    next(); idle_inputs();
    mid();
    check("c_result_gone", bus.result_valid_o, 0);

    // Out-of-order completion, in-order results, held under back-pressure
    next(); idle_inputs(); issue(3'd1, 5'd1, 1'b1, 1'b1);
    next(); idle_inputs(); issue(3'd2, 5'd2, 1'b1, 1'b1);
    next(); idle_inputs(); reg_ops(3'd1, 64'h10, 64'h11); commit(3'd1, 1'b0);
    next(); idle_inputs(); reg_ops(3'd2, 64'h20, 64'h21); commit(3'd2, 1'b0); bus.exec_ready_i = 1'b1;
    mid();
    check("e_exec1_valid", bus.exec_valid_o, 1);
    check("e_exec1_id",    bus.exec_id_o, 1);
    next(); idle_inputs(); bus.exec_ready_i = 1'b1;
    mid();
    check("e_exec2_valid", bus.exec_valid_o, 1);
    check("e_exec2_id",    bus.exec_id_o, 2);
    check("e_exec2_rs",    bus.exec_rs_o, {64'h20, 64'h21});
    next(); idle_inputs(); done(3'd2, 64'h200, 1'b0, 6'd0);
    mid();
    check("e_exec_idle", bus.exec_valid_o, 0);
    next(); idle_inputs(); done(3'd1, 64'h100, 1'b1, 6'd13);
    mid();
    check("e_no_result_out_of_order", bus.result_valid_o, 0);
    next(); idle_inputs();
    mid();
    check("e_r1_valid",   bus.result_valid_o, 1);
    check("e_r1_id",      bus.result_id_o, 1);
    check("e_r1_data",    bus.result_data_o, 64'h100);
    check("e_r1_exc",     bus.result_exc_o, 1);
    check("e_r1_exccode", bus.result_exccode_o, 13);
    check("e_r1_we",      bus.result_we_o, 0);
    check("e_r1_rd",      bus.result_rd_o, 1);
    for (int k = 0; k < 2; k++) begin
      next(); idle_inputs();
      mid();
      check($sformatf("e_hold%0d_valid", k), bus.result_valid_o, 1);
      check($sformatf("e_hold%0d_id", k),    bus.result_id_o, 1);
      check($sformatf("e_hold%0d_data", k),  bus.result_data_o, 64'h100);
      check($sformatf("e_hold%0d_code", k),  bus.result_exccode_o, 13);
    end
    next(); idle_inputs(); bus.result_ready_i = 1'b1;
    mid();
    check("e_r1_taken_id", bus.result_id_o, 1);
    next(); idle_inputs(); bus.result_ready_i = 1'b1;
    mid();
    check("e_r2_valid", bus.result_valid_o, 1);
    check("e_r2_id",    bus.result_id_o, 2);
    check("e_r2_data",  bus.result_data_o, 64'h200);
    check("e_r2_we",    bus.result_we_o, 1);
    check("e_r2_exc",   bus.result_exc_o, 0);
    next(); idle_inputs();
    mid();
    check("e_result_gone", bus.result_valid_o, 0);

    // Unknown register id, then reset with live entries
    next(); idle_inputs(); reg_ops(3'd6, 64'd1, 64'd1);
    mid();
    check("f_proto_err_not_yet", bus.proto_err_o, 0);
    next(); idle_inputs();
    mid();
    check("f_proto_err_set", bus.proto_err_o, 1);
    next(); next();
    mid();
    check("f_proto_err_sticky", bus.proto_err_o, 1);
    next(); idle_inputs(); issue(3'd5, 5'd5, 1'b1, 1'b1);
    next(); idle_inputs(); issue(3'd6, 5'd6, 1'b1, 1'b1);
    next(); idle_inputs(); reg_ops(3'd5, 64'd8, 64'd8);
    next(); idle_inputs(); rst = 1'b1;
    mid();
    check("f_rst_issue_ready",  bus.issue_ready_o, 0);
    check("f_rst_exec_valid",   bus.exec_valid_o, 0);
    check("f_rst_result_valid", bus.result_valid_o, 0);
    check("f_rst_proto_err",    bus.proto_err_o, 0);
    check("f_rst_reg_ready",    bus.register_ready_o, 1);
    next(); rst = 1'b0; commit(3'd5, 1'b0); bus.exec_ready_i = 1'b1;
    mid();
    check("f_post_ready", bus.issue_ready_o, 1);
    check("f_post_proto", bus.proto_err_o, 0);
    for (int k = 0; k < 2; k++) begin
      next(); idle_inputs(); bus.exec_ready_i = 1'b1; bus.result_ready_i = 1'b1;
      mid();
      check("f_post_no_exec",   bus.exec_valid_o, 0);
      check("f_post_no_result", bus.result_valid_o, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
